// File: rtl/obi_uart_rx.sv
// OBI UART receive engine: synchronises rx, frames 5-8 data bits with optional
// parity, and emits one-cycle character pushes with parity/framing/break flags.
module obi_uart_rx #(
    parameter int unsigned SyncStages = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       oversample_rate_edge_i,
    input  logic       rx_i,
    input  logic [1:0] word_len_i,
    input  logic       parity_en_i,
    input  logic       even_parity_i,
    input  logic       stick_parity_i,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    output logic       parity_err_o,
    output logic       framing_err_o,
    output logic       break_o,
    output logic       rx_busy_o
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } state_e;

    state_e                 state_q;
    logic [SyncStages-1:0]  sync_q;
    logic                   rx;
    logic [3:0]             tick_q;
    logic [2:0]             bitcnt_q;
    logic [7:0]             shift_q;
    logic                   par_q;
    logic [1:0]             wl_q;
    logic                   pen_q;
    logic                   even_q;
    logic                   stick_q;

    logic [2:0]             bit_last;
    logic [7:0]             data_w;
    logic                   par_exp;

    assign rx        = sync_q[SyncStages-1];
    assign rx_busy_o = (state_q != IDLE);
    assign bit_last  = {1'b0, wl_q} + 3'd4;

    // Bits shift in from the MSB, so short words sit high and stale bits below.
    assign data_w  = shift_q >> (3'd3 - {1'b0, wl_q});
    assign par_exp = stick_q ? ~even_q : (even_q ? ^data_w : ~^data_w);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SyncStages-2:0], rx_i};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            tick_q        <= 4'd0;
            bitcnt_q      <= 3'd0;
            shift_q       <= 8'd0;
            par_q         <= 1'b0;
            wl_q          <= 2'd0;
            pen_q         <= 1'b0;
            even_q        <= 1'b0;
            stick_q       <= 1'b0;
            rx_data_o     <= 8'd0;
            rx_valid_o    <= 1'b0;
            parity_err_o  <= 1'b0;
            framing_err_o <= 1'b0;
            break_o       <= 1'b0;
        end else begin
            rx_valid_o <= 1'b0;
            if (oversample_rate_edge_i) begin
                unique case (state_q)
                    IDLE: begin
                        if (!rx) begin
                            state_q <= START;
                            tick_q  <= 4'd0;
                            wl_q    <= word_len_i;
                            pen_q   <= parity_en_i;
                            even_q  <= even_parity_i;
                            stick_q <= stick_parity_i;
                        end
                    end
                    START: begin
                        tick_q <= tick_q + 4'd1;
                        if (tick_q == 4'd7) begin
                            tick_q   <= 4'd0;
                            bitcnt_q <= 3'd0;
                            state_q  <= rx ? IDLE : DATA;
                        end
                    end
                    DATA: begin
                        tick_q <= tick_q + 4'd1;
                        if (tick_q == 4'd15) begin
                            shift_q  <= {rx, shift_q[7:1]};
                            bitcnt_q <= bitcnt_q + 3'd1;
                            if (bitcnt_q == bit_last) begin
                                state_q <= pen_q ? PARITY : STOP;
                            end
                        end
                    end
                    PARITY: begin
                        tick_q <= tick_q + 4'd1;
                        if (tick_q == 4'd15) begin
                            par_q   <= rx;
                            state_q <= STOP;
                        end
                    end
                    STOP: begin
                        tick_q <= tick_q + 4'd1;
                        if (tick_q == 4'd15) begin
                            rx_valid_o    <= 1'b1;
                            rx_data_o     <= data_w;
                            parity_err_o  <= pen_q & (par_q != par_exp);
                            framing_err_o <= ~rx;
                            break_o       <= ~rx & (data_w == 8'd0)
                                             & ~(pen_q & par_q);
                            // A low stop bit must see the line recover first.
                            state_q       <= rx ? IDLE : WAIT_IDLE;
                        end
                    end
                    WAIT_IDLE: begin
                        if (rx) begin
                            state_q <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule
